// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} sub_state_t;

  localparam int SUB_N_DEFAULT = 4;

endpackage

// File: rtl/serial_sub_base_sub.sv
// Combinational 1-bit full subtractor cell used by the serial datapath.
module baseSub (
  input  logic a,
  input  logic b,
  input  logic Bin,
  output logic diff1,
  output logic Bout
);

  assign diff1 = a ^ b ^ Bin;
  assign Bout  = (~a & b) | (~(a ^ b) & Bin);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor, LSB first, start/busy/done handshake.
// Optional signed-overflow flag is built when SERIAL_SUB_OVERFLOW_EN is defined.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int N = SUB_N_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         Bout,
  output logic         busy,
`ifdef SERIAL_SUB_OVERFLOW_EN
  output logic         ovf,
`endif
  output logic         done
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  sub_state_t  state_q;
  logic [N-1:0] a_sh_q, b_sh_q, res_q, res_d;
  logic [N-1:0] diff_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic         br_q, bout_q, busy_q, done_q;
  logic         bit_d, bit_bout;
`ifdef SERIAL_SUB_OVERFLOW_EN
  // MSBs kept aside because the operand shift registers are consumed by the run.
  logic         a_msb_q, b_msb_q, ovf_q;
`endif

  baseSub u_cell (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .Bin  (br_q),
    .diff1(bit_d),
    .Bout (bit_bout)
  );

  assign res_d = {bit_d, res_q[N-1:1]};
  assign cnt_d = cnt_q + CW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (start) begin
            a_sh_q  <= a;
            b_sh_q  <= b;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
`ifdef SERIAL_SUB_OVERFLOW_EN
            a_msb_q <= a[N-1];
            b_msb_q <= b[N-1];
`endif
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          a_sh_q <= a_sh_q >> 1;
          b_sh_q <= b_sh_q >> 1;
          br_q   <= bit_bout;
          res_q  <= res_d;
          cnt_q  <= cnt_d;
          if (cnt_q == CNT_LAST) begin
            diff_q  <= res_d;
            bout_q  <= bit_bout;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
`ifdef SERIAL_SUB_OVERFLOW_EN
            ovf_q   <= (a_msb_q != b_msb_q) && (bit_d != a_msb_q);
`endif
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign diff = diff_q;
  assign Bout = bout_q;
  assign busy = busy_q;
  assign done = done_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_sub.sv
// Directed self-checking bench for serial_sub with N=4.
module tb_serial_sub;
  import serial_sub_pkg::*;

  localparam int N = 4;

  logic         clk, rst_n, start;
  logic [N-1:0] a, b, diff;
  logic         Bout, busy, done;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;

  serial_sub #(.N(N)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .diff (diff),
    .Bout (Bout),
    .busy (busy),
`ifdef SERIAL_SUB_OVERFLOW_EN
    .ovf  (ovf),
`endif
    .done (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one accepted start; returns #1 after the accepting edge with start low.
  task automatic start_op(input logic [N-1:0] av, input logic [N-1:0] bv);
    start = 1'b1; a = av; b = bv;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Bounded wait for done; cyc = edges seen, busy_n = samples with busy high before done.
  task automatic wait_done(output int cyc, output int busy_n);
    cyc = 0; busy_n = 0;
    while (!done && cyc < 20) begin
      if (busy) busy_n++;
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({diff, Bout, busy, done} !== '0) begin
      errors++; $display("FAIL reset_outputs got diff=%0d Bout=%b busy=%b done=%b expected all 0", diff, Bout, busy, done);
    end
    checks++;
    if (dut.state_q !== S_IDLE) begin
      errors++; $display("FAIL reset_state got %0d expected S_IDLE", dut.state_q);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    int cyc, bn;
    start_op(4'd9, 4'd3);
    wait_done(cyc, bn);
    checks++;
    if (cyc !== 4 || bn !== 4) begin
      errors++; $display("FAIL basic_latency got cyc=%0d busy=%0d expected 4/4", cyc, bn);
    end
    checks++;
    if (diff !== 4'd6 || Bout !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL basic_result got diff=%0d Bout=%b busy=%b expected 6/0/0", diff, Bout, busy);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || diff !== 4'd6) begin
      errors++; $display("FAIL basic_done_pulse got done=%b diff=%0d expected 0/6", done, diff);
    end
  endtask

  task automatic test_borrow;
    int cyc, bn;
    start_op(4'd3, 4'd9);
    wait_done(cyc, bn);
    checks++;
    if (diff !== 4'd10 || Bout !== 1'b1 || cyc !== 4) begin
      errors++; $display("FAIL borrow got diff=%0d Bout=%b cyc=%0d expected 10/1/4", diff, Bout, cyc);
    end
    @(posedge clk); #1;
    start_op(4'd0, 4'd0);
    checks++;
    if (diff !== 4'd10 || Bout !== 1'b1) begin
      errors++; $display("FAIL hold_during_run got diff=%0d Bout=%b expected 10/1", diff, Bout);
    end
    wait_done(cyc, bn);
    checks++;
    if (diff !== 4'd0 || Bout !== 1'b0 || cyc !== 4) begin
      errors++; $display("FAIL zero got diff=%0d Bout=%b cyc=%0d expected 0/0/4", diff, Bout, cyc);
    end
    @(posedge clk); #1;
  endtask

`ifdef SERIAL_SUB_OVERFLOW_EN
  task automatic test_overflow;
    int cyc, bn;
    start_op(4'd8, 4'd1);
    wait_done(cyc, bn);
    checks++;
    if (diff !== 4'd7 || Bout !== 1'b0 || ovf !== 1'b1) begin
      errors++; $display("FAIL ovf_set got diff=%0d Bout=%b ovf=%b expected 7/0/1", diff, Bout, ovf);
    end
    @(posedge clk); #1;
    checks++;
    if (ovf !== 1'b1) begin
      errors++; $display("FAIL ovf_hold got %b expected 1", ovf);
    end
    start_op(4'd5, 4'd2);
    wait_done(cyc, bn);
    checks++;
    if (diff !== 4'd3 || ovf !== 1'b0) begin
      errors++; $display("FAIL ovf_clear got diff=%0d ovf=%b expected 3/0", diff, ovf);
    end
    @(posedge clk); #1;
  endtask
`endif

  task automatic test_ignored_start;
    int dones = 0;
    start_op(4'd9, 4'd3);
    @(posedge clk); #1;
    start = 1'b1; a = 4'd15; b = 4'd15;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (done) begin
        dones++;
        checks++;
        if (diff !== 4'd6 || Bout !== 1'b0) begin
          errors++; $display("FAIL ignored_start_result got diff=%0d Bout=%b expected 6/0", diff, Bout);
        end
      end
      @(posedge clk); #1;
    end
    checks++;
    if (dones !== 1) begin
      errors++; $display("FAIL ignored_start_dones got %0d expected 1", dones);
    end
  endtask

  task automatic test_reset_abort;
    int dones = 0;
    int cyc, bn;
    start_op(4'd9, 4'd3);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({diff, Bout, busy, done} !== '0 || dut.state_q !== S_IDLE) begin
      errors++; $display("FAIL abort_outputs got diff=%0d Bout=%b busy=%b done=%b expected all 0", diff, Bout, busy, done);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (done || busy) dones++;
      @(posedge clk); #1;
    end
    checks++;
    if (dones !== 0) begin
      errors++; $display("FAIL abort_no_done got %0d active cycles expected 0", dones);
    end
    start_op(4'd12, 4'd5);
    wait_done(cyc, bn);
    checks++;
    if (diff !== 4'd7 || Bout !== 1'b0 || cyc !== 4) begin
      errors++; $display("FAIL after_abort got diff=%0d Bout=%b cyc=%0d expected 7/0/4", diff, Bout, cyc);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int cyc, bn, gap;
    start = 1'b1; a = 4'd7; b = 4'd2;
    @(posedge clk); #1;
    a = 4'd2; b = 4'd7;
    wait_done(cyc, bn);
    checks++;
    if (diff !== 4'd5 || Bout !== 1'b0 || cyc !== 4) begin
      errors++; $display("FAIL b2b_first got diff=%0d Bout=%b cyc=%0d expected 5/0/4", diff, Bout, cyc);
    end
    gap = 0;
    do begin
      @(posedge clk); #1;
      gap++;
      if (gap == 1) start = 1'b0;
    end while (!done && gap < 20);
    checks++;
    if (gap !== 5) begin
      errors++; $display("FAIL b2b_gap got %0d expected 5", gap);
    end
    checks++;
    if (diff !== 4'd11 || Bout !== 1'b1) begin
      errors++; $display("FAIL b2b_second got diff=%0d Bout=%b expected 11/1", diff, Bout);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL b2b_idle got done=%b busy=%b expected 0/0", done, busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_borrow();
`ifdef SERIAL_SUB_OVERFLOW_EN
    test_overflow();
`endif
    test_ignored_start();
    test_reset_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
